event_recorder: RTL and testbench
=================================

Name: event_recorder

Overview:
- Synchronous monitor for the event-display examples. Watches three W-bit signals `a`, `b` and `c`, and produces one timestamped record per clock edge on which any of them changed.
- Records are buffered in a small FIFO and drained by a valid/ready consumer.
- Sits directly downstream of the stimulus/always-block logic. It is the hardware counterpart of `$monitor`: it captures every value change, including cascaded `b`→`c` updates.

Parameters:
- W, 2, width of each watched signal
- TW, 16, timestamp width in cycles
- DEPTH, 8, FIFO entries (power of two, ≥2)
- RW, TW+4+3*W, record width (derived, not overridable)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a  in  W  watched signal a
- b  in  W  watched signal b
- c  in  W  watched signal c
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_data  out  RW  record: {ts[TW], posedge_a0, chg_c, chg_b, chg_a, a, b, c}
- overflow  out  1  sticky: at least one record was dropped
- drop_count  out  8  saturating count of dropped records
- level  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high) clears:
  - timestamp counter to 0
  - prev_a, prev_b, prev_c to 0
  - armed to 0
  - FIFO pointers and level to 0
  - out_valid to 0, overflow to 0, drop_count to 0
  - out_data to 0
- Reset asserted mid-operation discards all buffered records immediately. No partial record is emitted.
- Timestamp: free-running TW-bit counter, +1 every edge while out of reset, wraps from 2^TW-1 to 0 silently.
- Sampling, on every edge:
  - prev_x <= x for each watched signal.
  - armed <= 1.
  - The first edge after reset (armed=0) is the baseline only: no record, regardless of input values.
- Event detect, when armed:
  - chg_x = (x != prev_x) for each of a, b, c.
  - posedge_a0 = a[0] & ~prev_a[0].
  - An event exists if any chg bit is set. posedge_a0 alone cannot occur without chg_a.
- Record content: ts is the counter value before this edge's increment. a, b, c are the values sampled at this edge.
- Push latency: record written at the sampling edge. out_valid rises after that same edge if the FIFO was empty, i.e. one cycle from the input change being presented to the record being visible.
- Pop: the head is consumed on an edge with out_valid & out_ready. out_data shows the head entry combinationally from the FIFO array.
- Full plus event:
  - If a pop occurs on the same edge, the push is accepted (level unchanged).
  - Otherwise the record is dropped, overflow <= 1, and drop_count increments, saturating at 255.
- Empty plus pop request (out_ready with out_valid=0): no effect.
- Simultaneous push and pop when empty: push accepted, level goes 0→1. The popped-from-empty request is ignored.
- overflow and drop_count clear only on reset.
- X on inputs: not supported. Inputs must be driven to known values by the first edge after reset.

Decomposition:
- Shared package `event_recorder_pkg`:
  - field offset constants: TS_LSB, FLAG_POSEDGE_A0, CHG_C/CHG_B/CHG_A bit indices, A/B/C slice LSBs
  - function computing RW from W and TW
  - DROP_MAX = 255
- One natural sub-module: `sync_fifo`, parameterised on width and depth. It provides:
  - ptr + extra wrap bit
  - full/empty/level outputs
  - push-when-full-with-pop allowed
- The top level contains the detector, timestamp counter and drop logic.

Test Plan:
1. Reset, then hold a=b=c=0 for 5 edges → out_valid stays 0, level=0. The first edge produces no record even if a=1 at that edge.
2. After the baseline edge at ts=0, set a=1 before edge ts=1 → one record: ts=1, posedge_a0=1, chg_a=1, chg_b=0, chg_c=0, a=1, b=0, c=0. out_valid high one cycle later.
3. The model's cascade (b=3, c=3 in one cycle, then c=0 the next cycle) → two records: {chg_b=1, chg_c=1, b=3, c=3}, then {chg_c=1, c=0}, with consecutive ts.
4. out_ready=0, toggle a for 10 edges → level=8, overflow=1, drop_count=2. Then drain → 8 records with strictly increasing ts.
5. FIFO full while an event and a pop occur on the same edge → level stays 8, drop_count unchanged, new record is last out.
6. Assert reset with level=5 → out_valid=0, level=0 and overflow=0 asynchronously. Timestamp restarts at 0, and the first post-reset edge is the baseline only.

Source files
------------

// File: rtl/event_recorder_pkg.sv
// Shared record layout, derived widths and limits for the event recorder.
package event_recorder_pkg;

  localparam int unsigned DROP_MAX  = 255;
  localparam int unsigned DROP_W    = 8;
  localparam int unsigned NUM_FLAGS = 4;

  // Record layout, LSB first: c, b, a, chg_a, chg_b, chg_c, posedge_a0, ts
  function automatic int unsigned rec_width(input int unsigned w, input int unsigned tw);
    return tw + NUM_FLAGS + 3 * w;
  endfunction

  function automatic int unsigned c_lsb(input int unsigned w);
    return 0 * w;
  endfunction

  function automatic int unsigned b_lsb(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned a_lsb(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned chg_a_bit(input int unsigned w);
    return 3 * w;
  endfunction

  function automatic int unsigned chg_b_bit(input int unsigned w);
    return 3 * w + 1;
  endfunction

  function automatic int unsigned chg_c_bit(input int unsigned w);
    return 3 * w + 2;
  endfunction

  function automatic int unsigned flag_posedge_a0(input int unsigned w);
    return 3 * w + 3;
  endfunction

  function automatic int unsigned ts_lsb(input int unsigned w);
    return 3 * w + NUM_FLAGS;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// when a pop happens on the same edge.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level   = LW'(wr_ptr - rd_ptr);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    // Head is gated so a drained or freshly reset FIFO presents zero
    rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/event_recorder.sv
// Change monitor: emits one timestamped record per edge on which a, b or c
// changed, buffered in a FIFO and drained over valid/ready.
module event_recorder
  import event_recorder_pkg::*;
#(
  parameter  int unsigned W     = 2,
  parameter  int unsigned TW    = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned RW    = rec_width(W, TW),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W-1:0]      c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_data,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic [LW-1:0]     level
);

  localparam int unsigned TS_LSB   = ts_lsb(W);
  localparam int unsigned POS_BIT  = flag_posedge_a0(W);
  localparam int unsigned CHGC_BIT = chg_c_bit(W);
  localparam int unsigned CHGB_BIT = chg_b_bit(W);
  localparam int unsigned CHGA_BIT = chg_a_bit(W);
  localparam int unsigned A_LSB    = a_lsb(W);
  localparam int unsigned B_LSB    = b_lsb(W);
  localparam int unsigned C_LSB    = c_lsb(W);

  logic [TW-1:0] ts_q;
  logic [W-1:0]  prev_a_q;
  logic [W-1:0]  prev_b_q;
  logic [W-1:0]  prev_c_q;
  logic          armed_q;

  logic          chg_a;
  logic          chg_b;
  logic          chg_c;
  logic          evt;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [RW-1:0] rec;

  // Change detection and record assembly; nothing is recorded on the baseline edge
  always_comb begin
    chg_a = (a != prev_a_q);
    chg_b = (b != prev_b_q);
    chg_c = (c != prev_c_q);
    evt   = armed_q & (chg_a | chg_b | chg_c);
    drop  = evt & fifo_full & ~out_ready;

    rec                    = '0;
    rec[TS_LSB +: TW]      = ts_q;
    rec[POS_BIT]           = a[0] & ~prev_a_q[0];
    rec[CHGC_BIT]          = chg_c;
    rec[CHGB_BIT]          = chg_b;
    rec[CHGA_BIT]          = chg_a;
    rec[A_LSB +: W]        = a;
    rec[B_LSB +: W]        = b;
    rec[C_LSB +: W]        = c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      prev_c_q   <= '0;
      armed_q    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts_q     <= ts_q + TW'(1);
      prev_a_q <= a;
      prev_b_q <= b;
      prev_c_q <= c;
      armed_q  <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != DROP_W'(DROP_MAX)) drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt),
    .pop   (out_ready),
    .wdata (rec),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_event_recorder.sv
// Self-checking bench for event_recorder against a queue-based reference model.
module tb_event_recorder;

  localparam int unsigned W     = 2;
  localparam int unsigned TW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RW    = TW + 4 + 3 * W;
  localparam int unsigned LW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  a, b, c;
  logic          out_ready;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [LW-1:0] level;

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    logic [TW-1:0] ts;
    logic          pos;
    logic          cc, cb, ca;
    logic [W-1:0]  va, vb, vc;
  } rec_t;

  rec_t          q[$];
  logic [TW-1:0] m_ts;
  logic [W-1:0]  m_pa, m_pb, m_pc;
  bit            m_armed;
  bit            m_ovf;
  int            m_drops;

  event_recorder #(.W(W), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .c          (c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pack(input rec_t r);
    return {r.ts, r.pos, r.cc, r.cb, r.ca, r.va, r.vb, r.vc};
  endfunction

  function automatic logic [RW-1:0] head_exp();
    if (q.size() == 0) return '0;
    return pack(q[0]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ts = '0; m_pa = '0; m_pb = '0; m_pc = '0;
    m_armed = 0; m_ovf = 0; m_drops = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle past the edge
  task automatic tick(input logic [W-1:0] na, input logic [W-1:0] nb,
                      input logic [W-1:0] nc, input logic rdy);
    rec_t r;
    bit   ev;
    a = na; b = nb; c = nc; out_ready = rdy;
    @(posedge clk);
    ev = m_armed && (na != m_pa || nb != m_pb || nc != m_pc);
    r.ts = m_ts; r.pos = na[0] & ~m_pa[0];
    r.ca = (na != m_pa); r.cb = (nb != m_pb); r.cc = (nc != m_pc);
    r.va = na; r.vb = nb; r.vc = nc;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_pa = na; m_pb = nb; m_pc = nc; m_armed = 1;
    m_ts = m_ts + TW'(1);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    a = '0; b = '0; c = '0; out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || drop_count !== 8'd0 || out_data !== '0) begin
      failed++;
      $display("FAIL reset_state: got valid=%0b level=%0d ovf=%0b drops=%0d data=%0h required all zero",
               out_valid, level, overflow, drop_count, out_data);
    end
    model_reset();
    reset = 1'b0;
    tick(2'd1, 2'd0, 2'd0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      failed++;
      $display("FAIL baseline_edge: got valid=%0b level=%0d required 0/0", out_valid, level);
    end
    repeat (4) begin
      tick(2'd1, 2'd0, 2'd0, 1'b0);
      tests_run++;
      if (out_valid !== 1'b0 || level !== 4'd0) begin
        failed++;
        $display("FAIL quiet_hold: got valid=%0b level=%0d required 0/0", out_valid, level);
      end
    end
  endtask

  task automatic test_single_and_cascade();
    logic [RW-1:0] exp1, exp2, exp3;
    exp1 = {16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0};
    exp2 = {16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 2'd3};
    exp3 = {16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 2'd0};
    apply_reset();
    tick(2'd0, 2'd0, 2'd0, 1'b0);
    tick(2'd1, 2'd0, 2'd0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp1 || level !== 4'd1) begin
      failed++;
      $display("FAIL single_a: got valid=%0b data=%0h level=%0d required 1/%0h/1", out_valid, out_data, level, exp1);
    end
    tick(2'd1, 2'd3, 2'd3, 1'b0);
    tick(2'd1, 2'd3, 2'd0, 1'b0);
    tests_run++;
    if (level !== 4'd3) begin
      failed++;
      $display("FAIL cascade_level: got %0d required 3", level);
    end
    tick(2'd1, 2'd3, 2'd0, 1'b1);
    tests_run++;
    if (out_data !== exp2) begin
      failed++;
      $display("FAIL cascade_rec1: got %0h required %0h", out_data, exp2);
    end
    tick(2'd1, 2'd3, 2'd0, 1'b1);
    tests_run++;
    if (out_data !== exp3) begin
      failed++;
      $display("FAIL cascade_rec2: got %0h required %0h", out_data, exp3);
    end
    tick(2'd1, 2'd3, 2'd0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      failed++;
      $display("FAIL cascade_drained: got valid=%0b level=%0d required 0/0", out_valid, level);
    end
  endtask

  task automatic test_overflow();
    int last_ts;
    apply_reset();
    tick(2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 10; i++) tick(W'(i % 2), 2'd0, 2'd0, 1'b0);
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      failed++;
      $display("FAIL overflow_state: got level=%0d ovf=%0b drops=%0d required 8/1/2", level, overflow, drop_count);
    end
    last_ts = -1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== head_exp() || int'(out_data[RW-1 -: TW]) <= last_ts) begin
        failed++;
        $display("FAIL overflow_drain[%0d]: got valid=%0b data=%0h required 1/%0h (ts after %0d)",
                 i, out_valid, out_data, head_exp(), last_ts);
      end
      last_ts = int'(out_data[RW-1 -: TW]);
      tick(2'd0, 2'd0, 2'd0, 1'b1);
    end
    tests_run++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      failed++;
      $display("FAIL overflow_sticky: got valid=%0b ovf=%0b drops=%0d required 0/1/2", out_valid, overflow, drop_count);
    end
  endtask

  task automatic test_full_with_pop();
    logic [RW-1:0] last;
    apply_reset();
    tick(2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 8; i++) tick(W'(i % 2), 2'd0, 2'd0, 1'b0);
    tick(2'd0, 2'd2, 2'd0, 1'b1);
    tests_run++;
    if (level !== 4'd8 || drop_count !== 8'd0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL full_pop: got level=%0d drops=%0d ovf=%0b required 8/0/0", level, drop_count, overflow);
    end
    last = '0;
    for (int i = 0; i < 8; i++) begin
      last = out_data;
      tick(2'd0, 2'd2, 2'd0, 1'b1);
    end
    tests_run++;
    if (last[RW-1 -: TW] !== 16'd9 || last !== {16'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0}) begin
      failed++;
      $display("FAIL full_pop_last: got %0h required ts 9 b-change record", last);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick(2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 10; i++) tick(W'(i % 2), 2'd1, 2'd0, 1'b0);
    repeat (3) tick(2'd0, 2'd1, 2'd0, 1'b1);
    tests_run++;
    if (level !== 4'd5 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL mid_prefill: got level=%0d ovf=%0b required 5/1", level, overflow);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      failed++;
      $display("FAIL mid_async: got valid=%0b level=%0d ovf=%0b drops=%0d required 0/0/0/0",
               out_valid, level, overflow, drop_count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick(2'd3, 2'd1, 2'd2, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL mid_baseline: got valid=%0b required 0", out_valid);
    end
    tick(2'd2, 2'd1, 2'd2, 1'b0);
    tests_run++;
    if (out_data !== {16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 2'd2}) begin
      failed++;
      $display("FAIL mid_restart_ts: got %0h required ts 1 a-change record", out_data);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    tick(2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 270; i++) tick(2'd0, 2'd0, W'(i % 4), 1'b0);
    tests_run++;
    if (drop_count !== 8'd255 || drop_count !== 8'(m_drops) || level !== 4'd8) begin
      failed++;
      $display("FAIL saturate: got drops=%0d level=%0d required 255/8", drop_count, level);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rc;
    apply_reset();
    ra = '0; rb = '0; rc = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) ra = W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rc = W'($urandom_range(0, 3));
      tick(ra, rb, rc, ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3)));
      tests_run++;
      if (out_valid !== (q.size() > 0) || out_data !== head_exp() || level !== LW'(q.size())
          || overflow !== m_ovf || drop_count !== 8'(m_drops)) begin
        failed++;
        $display("FAIL random[%0d]: got v=%0b d=%0h l=%0d o=%0b n=%0d required v=%0b d=%0h l=%0d o=%0b n=%0d",
                 i, out_valid, out_data, level, overflow, drop_count,
                 q.size() > 0, head_exp(), q.size(), m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; c = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_and_cascade();
    test_overflow();
    test_full_with_pop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
